// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU sequencer.
// Holds the opcode map, the state encoding and the opcode validity check.
package uart_alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'h20;
    localparam logic [OP_W-1:0] OP_SUB = 6'h22;
    localparam logic [OP_W-1:0] OP_AND = 6'h24;
    localparam logic [OP_W-1:0] OP_OR  = 6'h25;
    localparam logic [OP_W-1:0] OP_XOR = 6'h26;
    localparam logic [OP_W-1:0] OP_NOR = 6'h27;
    localparam logic [OP_W-1:0] OP_SRA = 6'h03;
    localparam logic [OP_W-1:0] OP_SRL = 6'h02;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        COMPUTE = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        logic valid;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: valid = 1'b1;
            default:                        valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_frame_timer.sv
// Inter-byte timeout counter: clear has priority, counts while enabled,
// flags expiry on its last allowed cycle and saturates instead of wrapping.
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != COUNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == COUNT_LAST);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame sequencer: collects A, B, opcode from UART RX, drives the ALU,
// latches the result and launches a single UART TX of it.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err
);

    state_t             state_reg, state_next;
    logic [NB_DATA-1:0] alu_a_reg, alu_a_next;
    logic [NB_DATA-1:0] alu_b_reg, alu_b_next;
    logic [NB_OP-1:0]   alu_op_reg, alu_op_next;
    logic [NB_DATA-1:0] tx_data_reg, tx_data_next;
    logic               tx_start_reg, tx_start_next;
    logic               busy_reg, busy_next;
    logic               err_reg, err_next;

    logic byte_accept;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;
    logic op_valid;

    // Upper opcode-byte bits must be zero on top of a known opcode.
    assign op_valid = (i_rx_data[NB_DATA-1:NB_OP] == '0) &&
                      is_valid_op(i_rx_data[NB_OP-1:0]);

    assign timer_enable = (state_reg == WAIT_B) || (state_reg == WAIT_OP);
    assign timer_clear  = byte_accept || (state_next != state_reg);

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk    (clk),
        .rst    (i_rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= WAIT_A;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            alu_a_reg    <= alu_a_next;
            alu_b_reg    <= alu_b_next;
            alu_op_reg   <= alu_op_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            busy_reg     <= busy_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        alu_a_next   = alu_a_reg;
        alu_b_next   = alu_b_reg;
        alu_op_next  = alu_op_reg;
        tx_data_next = tx_data_reg;
        byte_accept  = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            WAIT_A: begin
                if (i_rx_done) begin
                    alu_a_next  = i_rx_data;
                    byte_accept = 1'b1;
                    state_next  = WAIT_B;
                end
            end
            WAIT_B: begin
                // A byte arriving on the expiry cycle still wins.
                if (i_rx_done) begin
                    alu_b_next  = i_rx_data;
                    byte_accept = 1'b1;
                    state_next  = WAIT_OP;
                end else if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    byte_accept = 1'b1;
                    if (op_valid) begin
                        alu_op_next = i_rx_data[NB_OP-1:0];
                        state_next  = COMPUTE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_A;
                    end
                end else if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = WAIT_A;
                end
            end
            COMPUTE: begin
                tx_data_next = i_alu_result;
                err_next     = i_rx_done;
                state_next   = SEND;
            end
            SEND: begin
                err_next   = i_rx_done;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                err_next = i_rx_done;
                if (i_tx_done) begin
                    state_next = WAIT_A;
                end
            end
            default: begin
                state_next = WAIT_A;
            end
        endcase

        // Back-to-back error sources must not stretch the pulse.
        err_next = err_next && !err_reg;
    end

    // Pulse/level outputs are registered off the next state so they line up
    // with the state they describe.
    assign tx_start_next = (state_next == SEND);
    assign busy_next     = (state_next == COMPUTE) || (state_next == SEND) ||
                           (state_next == WAIT_TX);

    assign o_alu_a    = alu_a_reg;
    assign o_alu_b    = alu_b_reg;
    assign o_alu_op   = alu_op_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_tx_start = tx_start_reg;
    assign o_busy     = busy_reg;
    assign o_err      = err_reg;

endmodule
